// File: rtl/match_pe_share_arbiter.sv
// Shares one match PE among NUM_REQ requesters: round-robin grant into a registered
// request slot, with a source-ID FIFO that routes in-order PE responses back to their channel.
module match_pe_share_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 25,
  parameter int unsigned TAG_BITS        = 2,
  parameter int unsigned MATCH_LEN_WIDTH = 8,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_head_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_history_addr,
  input  logic [NUM_REQ*TAG_BITS-1:0]          req_tag,
  output logic                                 pe_req_valid,
  input  logic                                 pe_req_ready,
  output logic [ADDR_WIDTH-1:0]                pe_req_head_addr,
  output logic [ADDR_WIDTH-1:0]                pe_req_history_addr,
  output logic [TAG_BITS-1:0]                  pe_req_tag,
  input  logic                                 pe_resp_valid,
  output logic                                 pe_resp_ready,
  input  logic [TAG_BITS-1:0]                  pe_resp_tag,
  input  logic [MATCH_LEN_WIDTH-1:0]           pe_resp_match_len,
  output logic [NUM_REQ-1:0]                   resp_valid,
  input  logic [NUM_REQ-1:0]                   resp_ready,
  output logic [NUM_REQ*TAG_BITS-1:0]          resp_tag,
  output logic [NUM_REQ*MATCH_LEN_WIDTH-1:0]   resp_match_len,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_cnt,
  output logic                                 proto_err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      grant_idx;
  logic [SRC_W-1:0]      rr_next;
  logic                  grant_any;
  logic                  slot_free;
  logic                  can_accept;
  logic                  req_fire;
  logic                  pe_fire;
  logic                  resp_fire;
  logic                  fifo_push;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      rd_ptr;
  logic [SRC_W-1:0]      head_src;
  logic [SRC_W-1:0]      src_mem [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] sel_head;
  logic [ADDR_WIDTH-1:0] sel_hist;
  logic [TAG_BITS-1:0]   sel_tag;

  assign pe_fire    = pe_req_valid & pe_req_ready;
  assign slot_free  = !pe_req_valid | pe_fire;
  assign can_accept = slot_free & (outstanding_cnt < CNT_W'(MAX_OUTSTANDING));
  assign req_fire   = grant_any & can_accept & !rst;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign fifo_push  = req_fire & !fifo_full;
  assign head_src   = src_mem[rd_ptr[IDX_W-1:0]];
  assign resp_fire  = pe_resp_valid & pe_resp_ready;
  assign rr_next    = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
  assign resp_tag       = {NUM_REQ{pe_resp_tag}};
  assign resp_match_len = {NUM_REQ{pe_resp_match_len}};

  // Round-robin search starting at rr_ptr, plus payload mux for the winner
  always_comb begin
    logic [SRC_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    sel_head  = '0;
    sel_hist  = '0;
    sel_tag   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = SRC_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_head = req_head_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_hist = req_history_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_tag  = req_tag[i*TAG_BITS +: TAG_BITS];
      end
    end
  end

  // Handshake fan-out: one ready toward the granted requester, one valid toward the FIFO head
  always_comb begin
    req_ready     = '0;
    resp_valid    = '0;
    pe_resp_ready = 1'b0;
    if (req_fire) req_ready[grant_idx] = 1'b1;
    if (!fifo_empty && !rst) begin
      resp_valid[head_src] = pe_resp_valid;
      pe_resp_ready        = resp_ready[head_src];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_req_valid        <= 1'b0;
      pe_req_head_addr    <= '0;
      pe_req_history_addr <= '0;
      pe_req_tag          <= '0;
      rr_ptr              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      outstanding_cnt     <= '0;
      proto_err           <= 1'b0;
    end else begin
      if (req_fire) begin
        pe_req_valid        <= 1'b1;
        pe_req_head_addr    <= sel_head;
        pe_req_history_addr <= sel_hist;
        pe_req_tag          <= sel_tag;
        rr_ptr              <= rr_next;
      end else if (pe_fire) begin
        pe_req_valid <= 1'b0;
      end
      if (fifo_push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (resp_fire) rd_ptr <= rd_ptr + CNT_W'(1);
      case ({req_fire, resp_fire})
        2'b10:   outstanding_cnt <= outstanding_cnt + CNT_W'(1);
        2'b01:   outstanding_cnt <= outstanding_cnt - CNT_W'(1);
        default: outstanding_cnt <= outstanding_cnt;
      endcase
      if (pe_resp_valid && fifo_empty) proto_err <= 1'b1;
    end
  end

  // Source-ID storage needs no reset; pointers alone define occupancy
  always_ff @(posedge clk) begin
    if (fifo_push) src_mem[wr_ptr[IDX_W-1:0]] <= grant_idx;
  end

endmodule

// File: tb/tb_match_pe_share_arbiter.sv
// Directed bench for match_pe_share_arbiter: expected PE requests and routed responses
// are queued by the stimulus and popped by an independent negedge monitor.
module tb_match_pe_share_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 25;
  localparam int unsigned TW = 2;
  localparam int unsigned LW = 8;

  typedef struct {
    logic [AW-1:0] head;
    logic [AW-1:0] hist;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct {
    int            lane;
    logic [TW-1:0] tag;
    logic [LW-1:0] len;
  } rsp_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [LW-1:0] len;
  } pe_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_ready;
  logic [NR*AW-1:0]    req_head_addr = '0;
  logic [NR*AW-1:0]    req_history_addr = '0;
  logic [NR*TW-1:0]    req_tag = '0;
  logic                pe_req_valid;
  logic                pe_req_ready = 1'b1;
  logic [AW-1:0]       pe_req_head_addr;
  logic [AW-1:0]       pe_req_history_addr;
  logic [TW-1:0]       pe_req_tag;
  logic                pe_resp_valid = 1'b0;
  logic                pe_resp_ready;
  logic [TW-1:0]       pe_resp_tag = '0;
  logic [LW-1:0]       pe_resp_match_len = '0;
  logic [NR-1:0]       resp_valid;
  logic [NR-1:0]       resp_ready = '1;
  logic [NR*TW-1:0]    resp_tag;
  logic [NR*LW-1:0]    resp_match_len;
  logic [3:0]          outstanding_cnt;
  logic                proto_err;

  // Staged controls, applied to the DUT just after each rising edge
  logic          rst_s    = 1'b1;
  logic          pe_rdy_s = 1'b1;
  logic          pe_en_s  = 1'b1;
  logic          force_s  = 1'b0;
  logic [NR-1:0] rr_s     = '1;

  req_t chq [NR][$];
  req_t exp_pe[$];
  rsp_t exp_resp[$];
  pe_t  pe_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fire_cnt = 0;
  int first_fire = 0;
  int last_fire  = 0;

  match_pe_share_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_head_addr       (req_head_addr),
    .req_history_addr    (req_history_addr),
    .req_tag             (req_tag),
    .pe_req_valid        (pe_req_valid),
    .pe_req_ready        (pe_req_ready),
    .pe_req_head_addr    (pe_req_head_addr),
    .pe_req_history_addr (pe_req_history_addr),
    .pe_req_tag          (pe_req_tag),
    .pe_resp_valid       (pe_resp_valid),
    .pe_resp_ready       (pe_resp_ready),
    .pe_resp_tag         (pe_resp_tag),
    .pe_resp_match_len   (pe_resp_match_len),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_tag            (resp_tag),
    .resp_match_len      (resp_match_len),
    .outstanding_cnt     (outstanding_cnt),
    .proto_err           (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: DUT produced an output with nothing expected (t=%0t)", nm, $time);
  endtask

  task automatic send(input int c, input logic [AW-1:0] h, input logic [AW-1:0] hs,
                      input logic [TW-1:0] t);
    req_t r;
    r.head = h; r.hist = hs; r.tag = t;
    chq[c].push_back(r);
  endtask

  // Expected PE request and, since the PE answers in order, the routed response
  task automatic expect_req(input int c, input logic [AW-1:0] h, input logic [AW-1:0] hs,
                            input logic [TW-1:0] t);
    req_t r;
    rsp_t s;
    r.head = h; r.hist = hs; r.tag = t;
    s.lane = c; s.tag = t; s.len = LW'(h + AW'(37));
    exp_pe.push_back(r);
    exp_resp.push_back(s);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_resp.size() != 0 || exp_pe.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(exp_resp.size() + exp_pe.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
  endtask

  // Input driver: requesters and the PE response side, both fed from queues
  always @(posedge clk) begin
    #1;
    rst          = rst_s;
    pe_req_ready = pe_rdy_s;
    resp_ready   = rr_s;
    for (int c = 0; c < NR; c++) begin
      if (chq[c].size() > 0) begin
        req_valid[c]                 = 1'b1;
        req_head_addr[c*AW +: AW]    = chq[c][0].head;
        req_history_addr[c*AW +: AW] = chq[c][0].hist;
        req_tag[c*TW +: TW]          = chq[c][0].tag;
      end else begin
        req_valid[c]                 = 1'b0;
        req_head_addr[c*AW +: AW]    = '0;
        req_history_addr[c*AW +: AW] = '0;
        req_tag[c*TW +: TW]          = '0;
      end
    end
    if (pe_en_s && pe_q.size() > 0) begin
      pe_resp_valid     = 1'b1;
      pe_resp_tag       = pe_q[0].tag;
      pe_resp_match_len = pe_q[0].len;
    end else if (force_s) begin
      pe_resp_valid     = 1'b1;
      pe_resp_tag       = 2'd2;
      pe_resp_match_len = 8'd5;
    end else begin
      pe_resp_valid     = 1'b0;
      pe_resp_tag       = '0;
      pe_resp_match_len = '0;
    end
  end

  // Monitor: checks every PE request and routed response against the scoreboard
  always @(negedge clk) begin
    req_t e;
    rsp_t s;
    pe_t  p;
    cyc++;
    chk("req_ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
    chk("resp_valid_onehot", 64'($countones(resp_valid) <= 1), 64'd1);
    if (pe_req_valid && pe_req_ready) begin
      if (exp_pe.size() == 0) unexpected("pe_req");
      else begin
        e = exp_pe.pop_front();
        chk("pe_req_head", 64'(pe_req_head_addr), 64'(e.head));
        chk("pe_req_hist", 64'(pe_req_history_addr), 64'(e.hist));
        chk("pe_req_tag", 64'(pe_req_tag), 64'(e.tag));
      end
      p.tag = pe_req_tag;
      p.len = LW'(pe_req_head_addr + AW'(37));
      pe_q.push_back(p);
      if (fire_cnt == 0) first_fire = cyc;
      last_fire = cyc;
      fire_cnt++;
    end
    for (int i = 0; i < NR; i++) begin
      if (resp_valid[i] && resp_ready[i]) begin
        if (exp_resp.size() == 0) unexpected("resp");
        else begin
          s = exp_resp.pop_front();
          chk("resp_lane", 64'(i), 64'(s.lane));
          chk("resp_tag", 64'(resp_tag[i*TW +: TW]), 64'(s.tag));
          chk("resp_len", 64'(resp_match_len[i*LW +: LW]), 64'(s.len));
        end
      end
    end
    if (pe_resp_valid && pe_resp_ready && pe_q.size() > 0) void'(pe_q.pop_front());
    for (int c = 0; c < NR; c++)
      if (req_valid[c] && req_ready[c] && chq[c].size() > 0) void'(chq[c].pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    chk("rst_pe_req_valid", 64'(pe_req_valid), 64'd0);
    chk("rst_cnt", 64'(outstanding_cnt), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_pe_resp_ready", 64'(pe_resp_ready), 64'd0);

    // Single request from ch2
    send(2, 25'h100, 25'h0F0, 2'd1);
    expect_req(2, 25'h100, 25'h0F0, 2'd1);
    @(negedge clk);
    chk("t1_req_ready", 64'(req_ready), 64'b0100);
    chk("t1_cnt0", 64'(outstanding_cnt), 64'd0);
    @(negedge clk);
    chk("t1_pe_req_valid", 64'(pe_req_valid), 64'd1);
    chk("t1_cnt1", 64'(outstanding_cnt), 64'd1);
    @(negedge clk);
    chk("t1_resp_valid", 64'(resp_valid), 64'b0100);
    chk("t1_resp_len2", 64'(resp_match_len[23:16]), 64'd37);
    chk("t1_cnt1b", 64'(outstanding_cnt), 64'd1);
    @(negedge clk);
    chk("t1_cnt_back0", 64'(outstanding_cnt), 64'd0);
    drain("t1_drain");

    // All channels continuously: grants 0,1,2,3 repeating at one per cycle
    do_reset();
    fire_cnt = 0;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < NR; c++) begin
        send(c, AW'(32'h1000 * (c + 1) + k), AW'(32'h20 * c + k), TW'(k));
        expect_req(c, AW'(32'h1000 * (c + 1) + k), AW'(32'h20 * c + k), TW'(k));
      end
    drain("t2_drain");
    chk("t2_fire_cnt", 64'(fire_cnt), 64'd12);
    chk("t2_throughput", 64'(last_fire - first_fire), 64'd11);

    // Backpressure: slot holds ch0, ch1 loads on the release cycle
    pe_rdy_s = 1'b0;
    send(0, 25'h200, 25'h0A0, 2'd2);
    send(1, 25'h300, 25'h0B0, 2'd3);
    expect_req(0, 25'h200, 25'h0A0, 2'd2);
    expect_req(1, 25'h300, 25'h0B0, 2'd3);
    @(negedge clk);
    chk("t3_first_grant", 64'(req_ready), 64'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(pe_req_valid), 64'd1);
      chk("t3_hold_head", 64'(pe_req_head_addr), 64'h200);
      chk("t3_hold_ready", 64'(req_ready), 64'd0);
    end
    pe_rdy_s = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", 64'(req_ready), 64'b0010);
    chk("t3_release_head", 64'(pe_req_head_addr), 64'h200);
    @(negedge clk);
    chk("t3_next_head", 64'(pe_req_head_addr), 64'h300);
    drain("t3_drain");

    // Outstanding limit with a silent PE
    pe_en_s = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send(3, AW'(32'h4000 + k), AW'(32'h60 + k), TW'(k));
      expect_req(3, AW'(32'h4000 + k), AW'(32'h60 + k), TW'(k));
    end
    repeat (14) @(negedge clk);
    chk("t4_cnt_full", 64'(outstanding_cnt), 64'd8);
    chk("t4_ready_blocked", 64'(req_ready), 64'd0);
    chk("t4_slot_empty", 64'(pe_req_valid), 64'd0);
    rr_s = 4'b1000;
    pe_en_s = 1'b1;
    @(negedge clk);
    chk("t4_resp_valid", 64'(resp_valid), 64'b1000);
    chk("t4_pe_resp_ready", 64'(pe_resp_ready), 64'd1);
    chk("t4_ready_still0", 64'(req_ready), 64'd0);
    pe_en_s = 1'b0;
    @(negedge clk);
    chk("t4_cnt7", 64'(outstanding_cnt), 64'd7);
    chk("t4_one_grant", 64'(req_ready), 64'b1000);
    @(negedge clk);
    chk("t4_cnt_refull", 64'(outstanding_cnt), 64'd8);
    chk("t4_blocked_again", 64'(req_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("t4_cnt_stable", 64'(outstanding_cnt), 64'd8);
    rr_s = '1;
    pe_en_s = 1'b1;
    drain("t4_drain");

    // Simultaneous request and response fire at count 4
    pe_en_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(0, AW'(32'h5000 + k), AW'(32'h70 + k), TW'(k));
      expect_req(0, AW'(32'h5000 + k), AW'(32'h70 + k), TW'(k));
    end
    repeat (8) @(negedge clk);
    chk("t5_cnt4", 64'(outstanding_cnt), 64'd4);
    send(1, 25'h6000, 25'h080, 2'd3);
    expect_req(1, 25'h6000, 25'h080, 2'd3);
    pe_en_s = 1'b1;
    @(negedge clk);
    chk("t5_req_fire", 64'(req_ready), 64'b0010);
    chk("t5_resp_fire", 64'(pe_resp_ready), 64'd1);
    chk("t5_resp_lane", 64'(resp_valid), 64'b0001);
    chk("t5_cnt_before", 64'(outstanding_cnt), 64'd4);
    pe_en_s = 1'b0;
    @(negedge clk);
    chk("t5_cnt_after", 64'(outstanding_cnt), 64'd4);
    pe_en_s = 1'b1;
    drain("t5_drain");
    @(negedge clk);
    chk("t5_cnt_drained", 64'(outstanding_cnt), 64'd0);

    // Response with nothing outstanding
    do_reset();
    pe_en_s = 1'b0;
    force_s = 1'b1;
    @(negedge clk);
    chk("t6_pe_resp_ready", 64'(pe_resp_ready), 64'd0);
    chk("t6_resp_valid", 64'(resp_valid), 64'd0);
    chk("t6_proto_pre", 64'(proto_err), 64'd0);
    @(negedge clk);
    chk("t6_proto_set", 64'(proto_err), 64'd1);
    chk("t6_pe_resp_ready2", 64'(pe_resp_ready), 64'd0);
    rst_s = 1'b1;
    force_s = 1'b0;
    @(negedge clk);
    chk("t6_proto_sticky", 64'(proto_err), 64'd1);
    @(negedge clk);
    chk("t6_rst_proto", 64'(proto_err), 64'd0);
    chk("t6_rst_cnt", 64'(outstanding_cnt), 64'd0);
    chk("t6_rst_pe_req_valid", 64'(pe_req_valid), 64'd0);
    chk("t6_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("t6_rst_pe_resp_ready", 64'(pe_resp_ready), 64'd0);
    rst_s = 1'b0;
    pe_en_s = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_pe_share_arbiter.md
Name: match_pe_share_arbiter

Overview:
- Shares one match PE between NUM_REQ job-PE request channels, e.g. a shared match PE behind the mesh or a local PE reused by several schedulers.
- Round-robin arbitration over request channels feeds a 1-entry registered request slot toward the PE.
- A source-ID FIFO records the grant order so in-order PE responses route back to the originating channel.
- Enforces a bound on outstanding requests (MAX_OUTSTANDING).

Parameters:
- NUM_REQ, 4, number of requester channels (≥2).
- ADDR_WIDTH, 25, head/history address width.
- TAG_BITS, 2, request tag width; carried through unchanged.
- MATCH_LEN_WIDTH, 8, response match length width.
- MAX_OUTSTANDING, 8, power of two; max requests accepted and not yet answered.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-channel request valid
- req_ready  out  NUM_REQ  per-channel request ready
- req_head_addr  in  NUM_REQ*ADDR_WIDTH  channel i at [i*ADDR_WIDTH+:ADDR_WIDTH]
- req_history_addr  in  NUM_REQ*ADDR_WIDTH  same packing
- req_tag  in  NUM_REQ*TAG_BITS  same packing
- pe_req_valid  out  1  request to match PE
- pe_req_ready  in  1  match PE accepts
- pe_req_head_addr  out  ADDR_WIDTH
- pe_req_history_addr  out  ADDR_WIDTH
- pe_req_tag  out  TAG_BITS
- pe_resp_valid  in  1  PE response valid; responses arrive in request order
- pe_resp_ready  out  1
- pe_resp_tag  in  TAG_BITS
- pe_resp_match_len  in  MATCH_LEN_WIDTH
- resp_valid  out  NUM_REQ  routed response valid
- resp_ready  in  NUM_REQ
- resp_tag  out  NUM_REQ*TAG_BITS  broadcast to all lanes
- resp_match_len  out  NUM_REQ*MATCH_LEN_WIDTH  broadcast to all lanes
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING)+1  accepted and not yet answered
- proto_err  out  1  sticky: pe_resp_valid seen with empty source FIFO

Behaviour:
- Reset (rst=1 at posedge): all outputs and state are cleared.
  - pe_req_valid=0, req_ready=0, resp_valid=0, pe_resp_ready=0, outstanding_cnt=0, proto_err=0.
  - Slot empty, FIFO empty, rr_ptr=0.
  - Reset mid-operation drops all in-flight bookkeeping; the PE is reset by the same rst.
- Slot free condition: slot_free = !slot_full | (pe_req_valid & pe_req_ready).
- Admission: can_accept = slot_free & (outstanding_cnt < MAX_OUTSTANDING).
- Arbitration (combinational):
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - req_ready[g] = can_accept for the granted channel only; all other req_ready=0.
  - req_ready does not depend on the channel's own req_valid beyond the grant search.
- On request fire (req_valid[g] & req_ready[g]):
  - Load the slot with head, history and tag; the slot is full next cycle.
  - Push g into the source FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - rr_ptr holds when no fire occurs.
- Request latency: 1 cycle from requester fire to pe_req_valid.
- The slot drives pe_req_* directly from registers, and its contents are stable while pe_req_valid & !pe_req_ready.
- Back-to-back operation: a PE fire and a new load in the same cycle sustain 1 request/cycle.
- Response routing (combinational, 0 latency):
  - head = FIFO head source ID.
  - resp_valid[head] = pe_resp_valid & !fifo_empty; all other lanes are 0.
  - pe_resp_ready = resp_ready[head] & !fifo_empty.
- Response fire pops the FIFO.
- Counter update:
  - outstanding_cnt +1 on request fire.
  - −1 on response fire.
  - Both in the same cycle: unchanged.
- Full: when outstanding_cnt == MAX_OUTSTANDING, all req_ready=0 until a response fires. The FIFO never overflows, because its depth equals MAX_OUTSTANDING.
- Empty FIFO with pe_resp_valid=1:
  - pe_resp_ready stays 0 and no resp_valid is raised.
  - proto_err is set and stays set until rst.
- Tags are passed through unmodified in both directions; the block never interprets them.
- Pointer arithmetic: FIFO pointers are $clog2(MAX_OUTSTANDING)+1 bits.
  - full = MSBs differ and LSBs equal.
  - Pointers wrap naturally.

Test Plan:
1. Single request: ch2 asserts head=0x100, hist=0x0F0, tag=1. Expect:
   - req_ready[2]=1 in the same cycle, pe_req_valid=1 with identical fields the next cycle.
   - PE replies match_len=37, tag=1, so resp_valid[2]=1, resp_match_len lane 2=37.
   - outstanding_cnt goes 0→1→0.
2. All 4 channels assert continuously with pe_req_ready=1 and the PE responding every cycle: grants follow 0,1,2,3,0,…, 1 grant/cycle, and each channel receives exactly its own tags in order.
3. Backpressure: pe_req_ready=0 for 5 cycles with ch1 pending. Expect:
   - The slot holds ch0's request stable.
   - req_ready all 0 after the slot fills.
   - On release, ch1 is loaded in the same cycle as ch0 fires.
4. Outstanding limit: PE accepts but never responds. Expect:
   - After 8 accepts, outstanding_cnt=8 and req_ready=0.
   - One response fire (source ch3, resp_ready[3]=1) drops the count to 7, and exactly one new grant follows.
5. Simultaneous request fire and response fire with outstanding_cnt=4: the count stays 4, the FIFO push and pop both occur, and ordering is preserved.
6. pe_resp_valid=1 after reset with nothing issued: proto_err=1 the next cycle, pe_resp_ready=0 and resp_valid=0. Asserting rst clears proto_err and all outputs the following cycle.
